calc_sequencer: RTL and testbench
=================================

Name: calc_sequencer

Overview:
- Operand-entry and execution sequencer for the keypad calculator.
- Sits between the matrix input manager's one-cycle key strobes and a shared BCD ALU.
- Builds operand A and operand B as BCD digit registers, latches the operator, and issues a start/done handshake to the ALU.
- Selects the BCD value driven to the seven-segment decoders.

Parameters:
DIGITS, 3, number of BCD digits per operand (register width 4*DIGITS)
TIMEOUT, 1023, max cycles to wait for alu_done before flagging error

Ports:
CLOCK_50  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
digit_pulse  input  1  one-cycle strobe: digit key pressed
digit  input  4  BCD value of pressed key, valid with digit_pulse
op_pulse  input  1  one-cycle strobe: operator key pressed
op  input  2  operator code (0 add, 1 sub, 2/3 reserved-as-given to ALU), valid with op_pulse
eq_pulse  input  1  one-cycle strobe: equals key
clr_pulse  input  1  one-cycle strobe: clear key
alu_done  input  1  one-cycle strobe from ALU, result valid
alu_result  input  4*DIGITS  BCD result, valid with alu_done
alu_overflow  input  1  result out of range, valid with alu_done
alu_start  output  1  one-cycle request to ALU
alu_op  output  2  latched operator
alu_a  output  4*DIGITS  operand A
alu_b  output  4*DIGITS  operand B
display  output  4*DIGITS  BCD value for HEX decoders
busy  output  1  high while waiting on ALU
err  output  1  high in ERR state

Behaviour:
- Reset is asynchronous, active-high. All outputs and registers go to 0. State is ENTER_A. Digit counters are 0.
- All outputs are registered. Inputs are sampled on the rising edge of CLOCK_50.
- Priority when pulses coincide: clr_pulse > eq_pulse > op_pulse > digit_pulse. Only the highest-priority pulse is acted on.
- digit_pulse with digit > 9 is ignored in every state.
- Digit entry: the target register shifts left one digit, {reg[4*DIGITS-5:0], digit}. Digit count increments.
- Digit entry when count == DIGITS: the digit is ignored (no wrap, no overflow flag).
- States and transitions:
  - ENTER_A:
    - digit: shifts into A.
    - op: latches alu_op, clears B and its count, goes to ENTER_B.
    - eq: ignored.
    - display = A.
  - ENTER_B:
    - digit: shifts into B.
    - op: overwrites alu_op and stays in ENTER_B.
    - eq: alu_start = 1 for exactly the next cycle, counter clears, goes to EXEC.
    - display = B.
  - EXEC:
    - busy = 1. alu_a, alu_b and alu_op are held stable.
    - digit, op and eq are ignored.
    - alu_done with alu_overflow = 0: latches alu_result into R, goes to SHOW.
    - alu_done with alu_overflow = 1: goes to ERR.
    - Counter reaches TIMEOUT without alu_done: goes to ERR.
    - display holds B.
  - SHOW:
    - display = R.
    - digit: A = that digit, count = 1, goes to ENTER_A.
    - op: A = R, count = DIGITS, latches op, clears B, goes to ENTER_B (chained operation).
    - eq: ignored.
  - ERR:
    - err = 1. display = 0.
    - Only clr leaves this state.
- clr_pulse in any state: next cycle is ENTER_A. A, B, R, counts, alu_op and err are cleared. busy and alu_start are 0.
- clr during EXEC aborts the operation. Any alu_done arriving later is ignored, because alu_done is only honoured in EXEC.
- alu_start is never asserted for two consecutive cycles. It asserts only on the ENTER_B→EXEC transition.
- display updates on the cycle after the causing pulse (latency 1).

Test Plan:
- reset; digits 1,2,3,4 → display 0x123 (4th digit ignored); A = 0x123.
- A = 0x045, op = 0, digits 7,0 → display 0x070, alu_op = 0. Then eq → alu_start high one cycle, busy high. Then alu_done with result 0x115 → display 0x115, busy low.
- In SHOW with R = 0x115: op = 1 → alu_a = 0x115, state ENTER_B, display 0x000. Then digit 5, eq, alu_done with result 0x110 → display 0x110.
- alu_done with alu_overflow = 1 → err = 1, display 0. Digits, op and eq are ignored. Then clr → err = 0, display 0.
- eq with no alu_done for TIMEOUT cycles → err = 1. A late alu_done after clr leaves state ENTER_A and A = 0.
- clr_pulse and digit_pulse in the same cycle during ENTER_A with A = 0x012 → A = 0x000. Assert reset mid-EXEC → all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/calc_sequencer.sv
// Keypad calculator sequencer: builds BCD operands A/B, latches the operator,
// runs the start/done handshake with the shared BCD ALU and selects the
// value shown on the seven-segment display.
module calc_sequencer #(
    parameter int unsigned DIGITS  = 3,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  digit_pulse,
    input  logic [3:0]            digit,
    input  logic                  op_pulse,
    input  logic [1:0]            op,
    input  logic                  eq_pulse,
    input  logic                  clr_pulse,
    input  logic                  alu_done,
    input  logic [4*DIGITS-1:0]   alu_result,
    input  logic                  alu_overflow,
    output logic                  alu_start,
    output logic [1:0]            alu_op,
    output logic [4*DIGITS-1:0]   alu_a,
    output logic [4*DIGITS-1:0]   alu_b,
    output logic [4*DIGITS-1:0]   display,
    output logic                  busy,
    output logic                  err
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned CW = $clog2(DIGITS + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        SHOW,
        ERR
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_r;
    logic [CW-1:0]   r_cnt_a;
    logic [CW-1:0]   r_cnt_b;
    logic [1:0]      r_op;
    logic [TW-1:0]   r_timer;
    logic            r_start;
    logic            r_busy;
    logic            r_err;
    logic [W-1:0]    r_display;

    state_t          w_state_nxt;
    logic [W-1:0]    w_a_nxt;
    logic [W-1:0]    w_b_nxt;
    logic [W-1:0]    w_r_nxt;
    logic [CW-1:0]   w_cnt_a_nxt;
    logic [CW-1:0]   w_cnt_b_nxt;
    logic [1:0]      w_op_nxt;
    logic [TW-1:0]   w_timer_nxt;
    logic            w_start_nxt;
    logic [W-1:0]    w_display_nxt;
    logic            w_digit_ok;
    logic            w_a_full;
    logic            w_b_full;

    // Digit keys above 9 are not BCD and never reach the operand registers.
    assign w_digit_ok = digit_pulse && (digit <= 4'd9);
    assign w_a_full   = (r_cnt_a == CW'(DIGITS));
    assign w_b_full   = (r_cnt_b == CW'(DIGITS));

    // State and datapath registers; every output is driven from one of these.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state   <= ENTER_A;
            r_a       <= '0;
            r_b       <= '0;
            r_r       <= '0;
            r_cnt_a   <= '0;
            r_cnt_b   <= '0;
            r_op      <= '0;
            r_timer   <= '0;
            r_start   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_display <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_a       <= w_a_nxt;
            r_b       <= w_b_nxt;
            r_r       <= w_r_nxt;
            r_cnt_a   <= w_cnt_a_nxt;
            r_cnt_b   <= w_cnt_b_nxt;
            r_op      <= w_op_nxt;
            r_timer   <= w_timer_nxt;
            r_start   <= w_start_nxt;
            r_busy    <= (w_state_nxt == EXEC);
            r_err     <= (w_state_nxt == ERR);
            r_display <= w_display_nxt;
        end
    end

    // Next-state logic; pulse priority is clr > eq > op > digit.
    always_comb begin
        w_state_nxt = r_state;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_r_nxt     = r_r;
        w_cnt_a_nxt = r_cnt_a;
        w_cnt_b_nxt = r_cnt_b;
        w_op_nxt    = r_op;
        w_timer_nxt = r_timer;
        w_start_nxt = 1'b0;

        if (clr_pulse) begin
            w_state_nxt = ENTER_A;
            w_a_nxt     = '0;
            w_b_nxt     = '0;
            w_r_nxt     = '0;
            w_cnt_a_nxt = '0;
            w_cnt_b_nxt = '0;
            w_op_nxt    = '0;
            w_timer_nxt = '0;
        end else begin
            case (r_state)
                ENTER_A: begin
                    if (eq_pulse) begin
                        w_state_nxt = ENTER_A;
                    end else if (op_pulse) begin
                        w_op_nxt    = op;
                        w_b_nxt     = '0;
                        w_cnt_b_nxt = '0;
                        w_state_nxt = ENTER_B;
                    end else if (w_digit_ok && !w_a_full) begin
                        w_a_nxt     = (r_a << 4) | W'(digit);
                        w_cnt_a_nxt = r_cnt_a + CW'(1);
                    end
                end
                ENTER_B: begin
                    if (eq_pulse) begin
                        w_start_nxt = 1'b1;
                        w_timer_nxt = '0;
                        w_state_nxt = EXEC;
                    end else if (op_pulse) begin
                        w_op_nxt    = op;
                    end else if (w_digit_ok && !w_b_full) begin
                        w_b_nxt     = (r_b << 4) | W'(digit);
                        w_cnt_b_nxt = r_cnt_b + CW'(1);
                    end
                end
                EXEC: begin
                    if (alu_done) begin
                        if (alu_overflow) begin
                            w_state_nxt = ERR;
                        end else begin
                            w_r_nxt     = alu_result;
                            w_state_nxt = SHOW;
                        end
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        w_state_nxt = ERR;
                    end else begin
                        w_timer_nxt = r_timer + TW'(1);
                    end
                end
                SHOW: begin
                    if (eq_pulse) begin
                        w_state_nxt = SHOW;
                    end else if (op_pulse) begin
                        // Chained operation: the previous result becomes A.
                        w_a_nxt     = r_r;
                        w_cnt_a_nxt = CW'(DIGITS);
                        w_op_nxt    = op;
                        w_b_nxt     = '0;
                        w_cnt_b_nxt = '0;
                        w_state_nxt = ENTER_B;
                    end else if (w_digit_ok) begin
                        w_a_nxt     = W'(digit);
                        w_cnt_a_nxt = CW'(1);
                        w_state_nxt = ENTER_A;
                    end
                end
                ERR: begin
                    w_state_nxt = ERR;
                end
                default: begin
                    w_state_nxt = ENTER_A;
                end
            endcase
        end
    end

    // Display source follows the state being entered so it lands one cycle after the pulse.
    always_comb begin
        w_display_nxt = '0;
        case (w_state_nxt)
            ENTER_A:       w_display_nxt = w_a_nxt;
            ENTER_B, EXEC: w_display_nxt = w_b_nxt;
            SHOW:          w_display_nxt = w_r_nxt;
            default:       w_display_nxt = '0;
        endcase
    end

    assign alu_start = r_start;
    assign alu_op    = r_op;
    assign alu_a     = r_a;
    assign alu_b     = r_b;
    assign display   = r_display;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: table of per-cycle vectors with expected outputs,
// expectations queued at drive time and compared after the clock edge.
module tb_calc_sequencer;

    localparam int unsigned DIGITS  = 3;
    localparam int unsigned TIMEOUT = 1023;
    localparam int unsigned W       = 4 * DIGITS;

    localparam bit [4:0] P_NONE = 5'b00000;
    localparam bit [4:0] P_CLR  = 5'b10000;
    localparam bit [4:0] P_EQ   = 5'b01000;
    localparam bit [4:0] P_OP   = 5'b00100;
    localparam bit [4:0] P_DIG  = 5'b00010;
    localparam bit [4:0] P_DONE = 5'b00001;

    typedef struct packed {
        logic         start;
        logic [1:0]   aop;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] disp;
        logic         busy;
        logic         err;
    } out_t;

    typedef struct {
        bit [4:0]     p;
        bit [1:0]     op;
        bit [3:0]     dig;
        bit           ovf;
        bit [W-1:0]   res;
        out_t         exp;
    } vec_t;

    logic           CLOCK_50;
    logic           reset;
    logic           digit_pulse;
    logic [3:0]     digit;
    logic           op_pulse;
    logic [1:0]     op;
    logic           eq_pulse;
    logic           clr_pulse;
    logic           alu_done;
    logic [W-1:0]   alu_result;
    logic           alu_overflow;
    logic           alu_start;
    logic [1:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   display;
    logic           busy;
    logic           err;

    int checks   = 0;
    int failures = 0;

    out_t  sb_q[$];
    string tag_q[$];
    vec_t  tbl[$];

    calc_sequencer #(.DIGITS(DIGITS), .TIMEOUT(TIMEOUT)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .digit_pulse  (digit_pulse),
        .digit        (digit),
        .op_pulse     (op_pulse),
        .op           (op),
        .eq_pulse     (eq_pulse),
        .clr_pulse    (clr_pulse),
        .alu_done     (alu_done),
        .alu_result   (alu_result),
        .alu_overflow (alu_overflow),
        .alu_start    (alu_start),
        .alu_op       (alu_op),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .display      (display),
        .busy         (busy),
        .err          (err)
    );

    initial CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    function automatic out_t o(input bit s, input bit [1:0] aop, input bit [W-1:0] a,
                               input bit [W-1:0] b, input bit [W-1:0] d, input bit bz, input bit e);
        out_t r;
        r.start = s; r.aop = aop; r.a = a; r.b = b; r.disp = d; r.busy = bz; r.err = e;
        return r;
    endfunction

    function automatic vec_t mk(input bit [4:0] p, input bit [1:0] opc, input bit [3:0] dg,
                                input bit ovf, input bit [W-1:0] res, input out_t e);
        vec_t v;
        v.p = p; v.op = opc; v.dig = dg; v.ovf = ovf; v.res = res; v.exp = e;
        return v;
    endfunction

    function automatic out_t cur();
        out_t r;
        r = {alu_start, alu_op, alu_a, alu_b, display, busy, err};
        return r;
    endfunction

    task automatic chk(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got start=%0b op=%0d a=%h b=%h disp=%h busy=%0b err=%0b, required start=%0b op=%0d a=%h b=%h disp=%h busy=%0b err=%0b",
                     name, act.start, act.aop, act.a, act.b, act.disp, act.busy, act.err,
                     exp.start, exp.aop, exp.a, exp.b, exp.disp, exp.busy, exp.err);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t v, input string tag);
        @(negedge CLOCK_50);
        clr_pulse    = v.p[4];
        eq_pulse     = v.p[3];
        op_pulse     = v.p[2];
        digit_pulse  = v.p[1];
        alu_done     = v.p[0];
        op           = v.op;
        digit        = v.dig;
        alu_overflow = v.ovf;
        alu_result   = v.res;
        sb_q.push_back(v.exp);
        tag_q.push_back(tag);
        @(posedge CLOCK_50);
        #1;
        chk(tag_q.pop_front(), cur(), sb_q.pop_front());
    endtask

    initial begin
        reset = 1'b1;
        digit_pulse = 1'b0; digit = '0; op_pulse = 1'b0; op = '0;
        eq_pulse = 1'b0; clr_pulse = 1'b0; alu_done = 1'b0;
        alu_result = '0; alu_overflow = 1'b0;

        // Operand entry, full-count ignore, invalid digits, eq ignored in ENTER_A
        tbl.push_back(mk(P_DIG, 0, 1, 0, 0, o(0,0,'h001,'h000,'h001,0,0)));
        tbl.push_back(mk(P_DIG, 0, 2, 0, 0, o(0,0,'h012,'h000,'h012,0,0)));
        tbl.push_back(mk(P_DIG, 0, 3, 0, 0, o(0,0,'h123,'h000,'h123,0,0)));
        tbl.push_back(mk(P_DIG, 0, 4, 0, 0, o(0,0,'h123,'h000,'h123,0,0)));
        tbl.push_back(mk(P_EQ,  0, 0, 0, 0, o(0,0,'h123,'h000,'h123,0,0)));
        tbl.push_back(mk(P_CLR, 0, 0, 0, 0, o(0,0,'h000,'h000,'h000,0,0)));
        tbl.push_back(mk(P_DIG, 0, 0, 0, 0, o(0,0,'h000,'h000,'h000,0,0)));
        tbl.push_back(mk(P_DIG, 0, 4, 0, 0, o(0,0,'h004,'h000,'h004,0,0)));
        tbl.push_back(mk(P_DIG, 0, 5, 0, 0, o(0,0,'h045,'h000,'h045,0,0)));
        tbl.push_back(mk(P_DIG, 0, 11,0, 0, o(0,0,'h045,'h000,'h045,0,0)));
        // Operator, B entry, execute, result
        tbl.push_back(mk(P_OP,  0, 0, 0, 0, o(0,0,'h045,'h000,'h000,0,0)));
        tbl.push_back(mk(P_DIG, 0, 12,0, 0, o(0,0,'h045,'h000,'h000,0,0)));
        tbl.push_back(mk(P_DIG, 0, 7, 0, 0, o(0,0,'h045,'h007,'h007,0,0)));
        tbl.push_back(mk(P_DIG, 0, 0, 0, 0, o(0,0,'h045,'h070,'h070,0,0)));
        tbl.push_back(mk(P_EQ,  0, 0, 0, 0, o(1,0,'h045,'h070,'h070,1,0)));
        tbl.push_back(mk(P_NONE,0, 0, 0, 0, o(0,0,'h045,'h070,'h070,1,0)));
        tbl.push_back(mk(P_DIG, 0, 9, 0, 0, o(0,0,'h045,'h070,'h070,1,0)));
        tbl.push_back(mk(P_OP,  3, 0, 0, 0, o(0,0,'h045,'h070,'h070,1,0)));
        tbl.push_back(mk(P_DONE,0, 0, 0,'h115, o(0,0,'h045,'h070,'h115,0,0)));
        // Chained operation from SHOW
        tbl.push_back(mk(P_OP,  1, 0, 0, 0, o(0,1,'h115,'h000,'h000,0,0)));
        tbl.push_back(mk(P_DIG, 0, 5, 0, 0, o(0,1,'h115,'h005,'h005,0,0)));
        tbl.push_back(mk(P_EQ,  0, 0, 0, 0, o(1,1,'h115,'h005,'h005,1,0)));
        tbl.push_back(mk(P_DONE,0, 0, 0,'h110, o(0,1,'h115,'h005,'h110,0,0)));
        // Digit from SHOW restarts A; op overwrite in ENTER_B; overflow to ERR
        tbl.push_back(mk(P_DIG, 0, 8, 0, 0, o(0,1,'h008,'h005,'h008,0,0)));
        tbl.push_back(mk(P_DIG, 0, 2, 0, 0, o(0,1,'h082,'h005,'h082,0,0)));
        tbl.push_back(mk(P_OP,  0, 0, 0, 0, o(0,0,'h082,'h000,'h000,0,0)));
        tbl.push_back(mk(P_DIG, 0, 3, 0, 0, o(0,0,'h082,'h003,'h003,0,0)));
        tbl.push_back(mk(P_OP,  1, 0, 0, 0, o(0,1,'h082,'h003,'h003,0,0)));
        tbl.push_back(mk(P_EQ,  0, 0, 0, 0, o(1,1,'h082,'h003,'h003,1,0)));
        tbl.push_back(mk(P_DONE,0, 0, 1,'h999, o(0,1,'h082,'h003,'h000,0,1)));
        tbl.push_back(mk(P_DIG, 0, 4, 0, 0, o(0,1,'h082,'h003,'h000,0,1)));
        tbl.push_back(mk(P_OP,  2, 0, 0, 0, o(0,1,'h082,'h003,'h000,0,1)));
        tbl.push_back(mk(P_EQ,  0, 0, 0, 0, o(0,1,'h082,'h003,'h000,0,1)));
        tbl.push_back(mk(P_DONE,0, 0, 0,'h123, o(0,1,'h082,'h003,'h000,0,1)));
        tbl.push_back(mk(P_CLR, 0, 0, 0, 0, o(0,0,'h000,'h000,'h000,0,0)));
        // Coinciding pulses and abort of EXEC by clr
        tbl.push_back(mk(P_DIG, 0, 0, 0, 0, o(0,0,'h000,'h000,'h000,0,0)));
        tbl.push_back(mk(P_DIG, 0, 1, 0, 0, o(0,0,'h001,'h000,'h001,0,0)));
        tbl.push_back(mk(P_DIG, 0, 2, 0, 0, o(0,0,'h012,'h000,'h012,0,0)));
        tbl.push_back(mk(P_CLR|P_DIG, 0, 7, 0, 0, o(0,0,'h000,'h000,'h000,0,0)));
        tbl.push_back(mk(P_OP|P_DIG,  2, 6, 0, 0, o(0,2,'h000,'h000,'h000,0,0)));
        tbl.push_back(mk(P_EQ|P_DIG,  0, 5, 0, 0, o(1,2,'h000,'h000,'h000,1,0)));
        tbl.push_back(mk(P_CLR|P_DONE,0, 0, 0,'h777, o(0,0,'h000,'h000,'h000,0,0)));
        tbl.push_back(mk(P_DONE,0, 0, 0,'h555, o(0,0,'h000,'h000,'h000,0,0)));

        repeat (2) @(negedge CLOCK_50);
        chk("reset_state", cur(), o(0,0,'h000,'h000,'h000,0,0));
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i], $sformatf("vec%0d", i));
        end

        // Timeout: EXEC waits TIMEOUT cycles, then ERR
        step(mk(P_DIG, 0, 1, 0, 0, o(0,0,'h001,'h000,'h001,0,0)), "to_dig_a");
        step(mk(P_OP,  0, 0, 0, 0, o(0,0,'h001,'h000,'h000,0,0)), "to_op");
        step(mk(P_DIG, 0, 2, 0, 0, o(0,0,'h001,'h002,'h002,0,0)), "to_dig_b");
        step(mk(P_EQ,  0, 0, 0, 0, o(1,0,'h001,'h002,'h002,1,0)), "to_eq");
        for (int i = 0; i < int'(TIMEOUT) - 1; i++) begin
            step(mk(P_NONE, 0, 0, 0, 0, o(0,0,'h001,'h002,'h002,1,0)), $sformatf("to_wait%0d", i));
        end
        step(mk(P_NONE, 0, 0, 0, 0, o(0,0,'h001,'h002,'h000,0,1)), "to_err");
        step(mk(P_CLR,  0, 0, 0, 0, o(0,0,'h000,'h000,'h000,0,0)), "to_clr");
        step(mk(P_DONE, 0, 0, 0,'h321, o(0,0,'h000,'h000,'h000,0,0)), "to_late_done");

        // Asynchronous reset in the middle of EXEC
        step(mk(P_DIG, 0, 3, 0, 0, o(0,0,'h003,'h000,'h003,0,0)), "rst_dig_a");
        step(mk(P_OP,  1, 0, 0, 0, o(0,1,'h003,'h000,'h000,0,0)), "rst_op");
        step(mk(P_DIG, 0, 4, 0, 0, o(0,1,'h003,'h004,'h004,0,0)), "rst_dig_b");
        step(mk(P_EQ,  0, 0, 0, 0, o(1,1,'h003,'h004,'h004,1,0)), "rst_eq");
        step(mk(P_NONE,0, 0, 0, 0, o(0,1,'h003,'h004,'h004,1,0)), "rst_exec");
        @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1 chk("async_reset", cur(), o(0,0,'h000,'h000,'h000,0,0));
        @(negedge CLOCK_50);
        reset = 1'b0;
        step(mk(P_NONE,0, 0, 0, 0, o(0,0,'h000,'h000,'h000,0,0)), "post_rst_idle");
        step(mk(P_DIG, 0, 6, 0, 0, o(0,0,'h006,'h000,'h006,0,0)), "post_rst_dig");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
